// File: rtl/tsc_pkg.sv
// Shared constants for the transient-capture host receiver: FSM state codes,
// serial line levels and sizes agreed with the capture side.
package tsc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ARM       = 4'd1;
    localparam state_t ST_WAIT_TRIG = 4'd2;
    localparam state_t ST_REQ       = 4'd3;
    localparam state_t ST_WAIT_SB   = 4'd4;
    localparam state_t ST_DATA      = 4'd5;
    localparam state_t ST_STOP      = 4'd6;
    localparam state_t ST_DONE      = 4'd7;
    localparam state_t ST_ERR       = 4'd8;

    localparam logic SD_IDLE  = 1'b1;
    localparam logic SD_START = 1'b0;

    localparam int DATA_BITS     = 8;
    localparam int BUF_BYTES_DEF = 32;
    localparam int TIMEOUT_DEF   = 64;

    localparam logic [7:0] TRIG_CODE = 8'hD5;

endpackage

// File: rtl/tsc_sd_deser.sv
// SD byte deserialiser: counts data bits MSB first into a shift register and
// classifies the stop bit as a good byte or a framing error.
module tsc_sd_deser
    import tsc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sd_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic                 stop_i,
    output logic                 last_bit_o,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_valid_o,
    output logic                 frame_err_o
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] IDX_FIRST = IW'(DATA_BITS - 1);

    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (load_i) begin
            idx_d = IDX_FIRST;
        end else if (shift_i) begin
            idx_d   = idx_q - 1'b1;
            shreg_d = {shreg_q[DATA_BITS-2:0], sd_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end

    // Shift data needs no reset: it is only consumed after a full frame.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign last_bit_o   = (idx_q == '0);
    assign byte_o       = shreg_q;
    assign byte_valid_o = stop_i && (sd_i == SD_IDLE);
    assign frame_err_o  = stop_i && (sd_i != SD_IDLE);

endmodule

// File: rtl/tsc_host_rx.sv
// Host-side receiver: arms a capture, waits for TRD, requests the dump with SBF
// and stores the deserialised SD bytes in a register buffer with a registered read port.
module tsc_host_rx
    import tsc_pkg::*;
#(
    parameter int BUF_BYTES   = BUF_BYTES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       TRD,
    input  logic                       SD,
    output logic                       start,
    output logic                       SBF,
    input  logic [$clog2(BUF_BYTES)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    output logic [$clog2(BUF_BYTES):0] byte_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int AW = $clog2(BUF_BYTES);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_BYTES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [BUF_BYTES];
    logic          wr_en;

    logic       last_bit, byte_valid, frame_err;
    logic [7:0] rx_byte;

    tsc_sd_deser u_deser (
        .clk          (clk),
        .reset        (reset),
        .sd_i         (SD),
        .load_i       ((state_q == ST_WAIT_SB) && (SD == SD_START)),
        .shift_i      (state_q == ST_DATA),
        .stop_i       (state_q == ST_STOP),
        .last_bit_o   (last_bit),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (arm) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM:       state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (TRD) state_d = ST_REQ;
            ST_REQ:       state_d = ST_WAIT_SB;
            ST_WAIT_SB: begin
                // A start bit on the last allowed idle cycle still wins over the timeout.
                if (SD == SD_START)          state_d = ST_DATA;
                else if (tmo_q == TMO_LAST)  state_d = ST_ERR;
                else                         tmo_d   = tmo_q + 1'b1;
            end
            ST_DATA:      if (last_bit) state_d = ST_STOP;
            ST_STOP: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    wr_en = (cnt_q != CNT_FULL);
                    if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
                    state_d = (cnt_q + 1'b1 >= CNT_FULL) ? ST_DONE : ST_WAIT_SB;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    // Buffer contents survive reset so a host can still read the last dump.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[cnt_q[AW-1:0]] <= rx_byte;
    end

    assign start    = (state_q == ST_ARM);
    assign SBF      = (state_q == ST_REQ);
    assign busy     = (state_q >= ST_ARM) && (state_q <= ST_STOP);
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign byte_cnt = cnt_q;
    assign rd_data  = rd_data_q;

endmodule
